// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment display blocks.
package seg7_pkg;

    // Segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Team-standard hex glyphs; anything unexpected falls back to dark.
    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to seven-segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output seg_t       o_seg
);

    // Pure table lookup; registering is left to the caller.
    always_comb begin
        o_seg = hex_to_seg(i_hex);
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed N-digit seven-segment scanner with blank/blink masks
// and per-slot dead time to suppress ghosting between digits.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 4,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic                    i_load,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic [NUM_DIGITS-1:0]   i_blink,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame
);

    localparam int D_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int P_W = $clog2(SCAN_DIV);
    localparam int B_W = $clog2(BLINK_DIV);

    localparam logic [D_W-1:0] D_LAST = D_W'(NUM_DIGITS - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(SCAN_DIV - 1);
    localparam logic [P_W-1:0] P_DEAD = P_W'(DEAD_CYCLES);
    localparam logic [B_W-1:0] B_LAST = B_W'(BLINK_DIV - 1);

    // Shadow copies of the display content.
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;

    // Scan position, blink timebase.
    logic [P_W-1:0] p_q, p_d;
    logic [D_W-1:0] d_q, d_d;
    logic [B_W-1:0] bcnt_q, bcnt_d;
    logic           phase_q, phase_d;

    // Registered pin outputs.
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic [3:0] cur_hex;
    seg_t       cur_seg;
    logic       cur_dark;

    assign cur_hex = digits_q[4*d_q +: 4];

    seg7_hex_decode u_dec (
        .i_hex (cur_hex),
        .o_seg (cur_seg)
    );

    // Shadow capture and counter advance; terminal values compared explicitly.
    always_comb begin
        digits_d = digits_q;
        blank_d  = blank_q;
        blink_d  = blink_q;
        if (i_load) begin
            digits_d = i_digits;
            blank_d  = i_blank;
            blink_d  = i_blink;
        end

        p_d = p_q;
        d_d = d_q;
        if (p_q == P_LAST) begin
            p_d = '0;
            d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;
        end else begin
            p_d = p_q + 1'b1;
        end

        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (bcnt_q == B_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    // Next pin values from the current scan position and shadows.
    always_comb begin
        cur_dark = blank_q[d_q] | (blink_q[d_q] & phase_q);
        an_d     = '1;
        seg_d    = SEG_BLANK;
        if (p_q >= P_DEAD) begin
            an_d[d_q] = 1'b0;
            if (!cur_dark) begin
                seg_d = cur_seg;
            end
        end
        frame_d = (d_q == '0) && (p_q == '0);
    end

    // State and output registers; reset restarts the scan at digit 0 with dead time.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            digits_q <= '0;
            blank_q  <= '1;
            blink_q  <= '0;
            p_q      <= '0;
            d_q      <= '0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
            seg_q    <= SEG_BLANK;
            an_q     <= '1;
            frame_q  <= 1'b0;
        end else begin
            digits_q <= digits_d;
            blank_q  <= blank_d;
            blink_q  <= blink_d;
            p_q      <= p_d;
            d_q      <= d_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed, parametrised seven-segment display driver for N hex digits on a shared segment bus. It latches a packed digit word plus per-digit blank and blink masks on a load strobe, then scans digits one at a time with an active-low anode select and anti-ghosting dead time. It sits between the counter/clock logic and the board pins and replaces the fixed two-digit, one-decoder-per-digit wiring.

## Interface
- NUM_DIGITS, 4: number of digits scanned; legal range 2..16.
- SCAN_DIV, 50000: clock cycles per digit slot; must be greater than DEAD_CYCLES + 1.
- DEAD_CYCLES, 4: cycles at the start of each slot during which all anodes are off; 0 is legal.
- BLINK_DIV, 25000000: clock cycles per blink half-period; minimum 2.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_digits  in  4*NUM_DIGITS  hex digit values; digit k is [4k+3:4k]; digit 0 is rightmost.
- i_load  in  1  capture i_digits, i_blank and i_blink into the shadow registers.
- i_blank  in  NUM_DIGITS  per-digit blank mask; 1 forces the digit dark.
- i_blink  in  NUM_DIGITS  per-digit blink enable.
- o_seg  out  7  segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
- o_an  out  NUM_DIGITS  digit enable, one-hot active-low.
- o_frame  out  1  one-cycle pulse at the start of each digit-0 slot.

## Operation
- Reset, with i_rst_n low at an edge, sets the following. Internal state: shadow digits = 0, shadow blank = all ones, shadow blink = 0, prescaler p = 0, digit index d = 0, blink counter = 0, blink phase = 0. Outputs: o_seg = 7'b1111111, o_an = all ones, o_frame = 0.
- **Load:** i_load high at an edge copies all three inputs into the shadows at that edge. Consecutive loads are allowed. Loads are ignored while reset is asserted.
- **Prescaler:** p counts 0..SCAN_DIV-1. When p reaches SCAN_DIV-1, it returns to 0 and d advances, wrapping from NUM_DIGITS-1 to 0.
- **Blink:** the blink counter counts 0..BLINK_DIV-1. When it wraps, the blink phase toggles. It runs independently of the scan.
- **Dark digit:** digit d is dark when shadow_blank[d] = 1, or when shadow_blink[d] = 1 and blink phase = 1.
- **Output registers** are computed from the current p, d, phase and shadows, and update every cycle:
  - When p < DEAD_CYCLES: o_an = all ones and o_seg = 7'b1111111.
  - Otherwise: o_an has bit d low and all other bits high. o_seg = 7'b1111111 if the digit is dark, else hex_to_seg(shadow digit d).
  - o_frame = 1 exactly when d = 0 and p = 0.
- **Hex patterns** are the team standard, for example: 0 = 1000000, 1 = 1111001, 7 = 1111000, 8 = 0000000, 9 = 0011000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- **Width rules:**
  - d is max(1, $clog2(NUM_DIGITS)) bits.
  - p is $clog2(SCAN_DIV) bits.
  - The blink counter is $clog2(BLINK_DIV) bits.
  - Counters compare against the terminal value explicitly; they never rely on natural overflow.

## Timing
- All outputs are registered. They reflect the state of the previous cycle, giving one cycle of latency from the p/d change.
- i_load at edge n updates the shadows at edge n. o_seg shows the new value at edge n+1 if that digit is active and outside dead time.
- A load coinciding with a slot change takes effect at edge n+1 in the new slot; the old value for the new digit is never shown.
- Reset asserted mid-slot: the outputs reach their reset values at the same edge, and scanning restarts from digit 0 with dead time.
- Frame period is NUM_DIGITS*SCAN_DIV cycles. Each anode is low for SCAN_DIV-DEAD_CYCLES consecutive cycles per frame.
- Two anodes are never low in the same cycle.

## Structure
- Package seg7_pkg contains:
  - constant SEG_BLANK = 7'b1111111;
  - typedef seg_t for the 7-bit segment pattern;
  - function hex_to_seg(4-bit) returning seg_t, default SEG_BLANK.
- Sub-module seg7_hex_decode is a combinational wrapper around hex_to_seg. The existing two-digit board glue reuses it.
- The scan, blink and shadow logic all live in seg7_scan. No further hierarchy.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2, BLINK_DIV=64.
- **Reset:** hold i_rst_n low for 3 cycles, then release -> o_seg=1111111, o_an=1111 during reset; after release, the first o_frame pulse comes 1 cycle later and o_an stays 1111 for 2 cycles.
- **Scan:** load i_digits=16'h12AF, blank=0, blink=0 -> per frame, o_an cycles 1110,1101,1011,0111 with o_seg F=0001110, A=0001000, 2=0100100, 1=1111001; 6 active cycles per slot; o_frame period 32.
- **Blank:** load blank=4'b0100 -> during digit 2's slot o_an=1011 and o_seg=1111111; the other digits are unchanged.
- **Blink:** load blink=4'b0001, digits=16'h0008 -> digit 0 shows 0000000 for 64 cycles, then 1111111 for 64 cycles, repeating; the other digits show 1000000 continuously.
- **Load at slot boundary:** pulse i_load in the cycle where p=7, d=0, with digit 1 changing 3->5 -> digit 1 never shows 0110000; it shows 0010010 from the first active cycle.
- **Mid-scan reset:** assert reset while d=2, p=5 -> outputs blank at that edge; after release, scanning restarts at digit 0 with blank=1111 (display dark until the next load).
